// File: rtl/vp_cfg_ctrl_if.sv
// Register-bus side of the video-processing configuration sequencer: the four
// configuration words, the update strobe and the status flags.
interface vp_cfg_ctrl_if;
    logic [31:0] vp_cr;
    logic [31:0] vp_start;
    logic [31:0] vp_end;
    logic [31:0] vp_scaler;
    logic        cfg_update;
    logic        cfg_busy;
    logic        cfg_err;

    modport master (
        output vp_cr, vp_start, vp_end, vp_scaler, cfg_update,
        input  cfg_busy, cfg_err
    );

    modport slave (
        input  vp_cr, vp_start, vp_end, vp_scaler, cfg_update,
        output cfg_busy, cfg_err
    );
endinterface

// File: rtl/vp_cfg_ctrl.sv
// Configuration sequencer: snapshots bus words, range-checks them, and commits
// valid configurations to the datapath only on a vsync rising edge.
module vp_cfg_ctrl #(
    parameter int unsigned H_DISP             = 1280,
    parameter int unsigned V_DISP             = 720,
    parameter int unsigned INPUT_X_RES_WIDTH  = 11,
    parameter int unsigned INPUT_Y_RES_WIDTH  = 11,
    parameter int unsigned OUTPUT_X_RES_WIDTH = 11,
    parameter int unsigned OUTPUT_Y_RES_WIDTH = 11,
    parameter int unsigned SYNC_STAGES        = 2
) (
    input  logic                          clk_vp,
    input  logic                          rst_n,
    vp_cfg_ctrl_if.slave                  cfg_bus,
    input  logic                          vi_vs_i,
    output logic                          cuter_en_o,
    output logic [1:0]                    filter_mode_o,
    output logic                          scaler_en_o,
    output logic [INPUT_X_RES_WIDTH-1:0]  start_x_o,
    output logic [INPUT_X_RES_WIDTH-1:0]  end_x_o,
    output logic [INPUT_Y_RES_WIDTH-1:0]  start_y_o,
    output logic [INPUT_Y_RES_WIDTH-1:0]  end_y_o,
    output logic [INPUT_X_RES_WIDTH-1:0]  input_x_res_o,
    output logic [INPUT_Y_RES_WIDTH-1:0]  input_y_res_o,
    output logic [OUTPUT_X_RES_WIDTH-1:0] output_x_res_o,
    output logic [OUTPUT_Y_RES_WIDTH-1:0] output_y_res_o,
    output logic                          apply_pulse_o,
    output logic [15:0]                   frame_cnt_o
);
    localparam int unsigned XW  = INPUT_X_RES_WIDTH;
    localparam int unsigned YW  = INPUT_Y_RES_WIDTH;
    localparam int unsigned OXW = OUTPUT_X_RES_WIDTH;
    localparam int unsigned OYW = OUTPUT_Y_RES_WIDTH;

    localparam logic [XW-1:0]  HDisp   = XW'(H_DISP);
    localparam logic [YW-1:0]  VDisp   = YW'(V_DISP);
    localparam logic [XW-1:0]  HDispM1 = XW'(H_DISP - 1);
    localparam logic [YW-1:0]  VDispM1 = YW'(V_DISP - 1);
    localparam logic [OXW-1:0] HOutM1  = OXW'(H_DISP - 1);
    localparam logic [OYW-1:0] VOutM1  = OYW'(V_DISP - 1);
    // cr fields: {scaler_en, filter_mode, cuter_en}
    localparam logic [3:0]     CrDflt  = 4'b1010;

    typedef enum logic [1:0] {StIdle, StCheck, StPending, StApply} state_e;

    state_e state_q, state_d;
    logic   req_q, req_d;
    logic   err_q, err_d;
    logic   apply_q, apply_d;
    logic   snap_take, load;

    logic [SYNC_STAGES-1:0] vs_sync_q;
    logic                   vs_d1_q;
    logic                   vs_rise;
    logic [15:0]            frame_cnt_q;

    logic [3:0]     snap_cr_q, act_cr_q;
    logic [XW-1:0]  snap_sx_q, snap_ex_q, act_sx_q, act_ex_q, act_ix_q;
    logic [YW-1:0]  snap_sy_q, snap_ey_q, act_sy_q, act_ey_q, act_iy_q;
    logic [OXW-1:0] snap_ox_q, act_ox_q;
    logic [OYW-1:0] snap_oy_q, act_oy_q;
    logic           snap_valid;

    assign vs_rise = vs_sync_q[SYNC_STAGES-1] & ~vs_d1_q;

    always_ff @(posedge clk_vp or negedge rst_n) begin
        if (!rst_n) begin
            vs_sync_q   <= '0;
            vs_d1_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            vs_sync_q <= {vs_sync_q[SYNC_STAGES-2:0], vi_vs_i};
            vs_d1_q   <= vs_sync_q[SYNC_STAGES-1];
            if (vs_rise) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign snap_valid = (snap_sx_q < snap_ex_q) && (snap_ex_q <= HDisp) &&
                        (snap_sy_q < snap_ey_q) && (snap_ey_q <= VDisp) &&
                        (snap_ox_q <= HOutM1) && (snap_oy_q <= VOutM1);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        err_d     = err_q;
        apply_d   = 1'b0;
        snap_take = 1'b0;
        load      = 1'b0;
        case (state_q)
            StIdle: begin
                if (cfg_bus.cfg_update || req_q) begin
                    snap_take = 1'b1;
                    req_d     = 1'b0;
                    state_d   = StCheck;
                end
            end
            StCheck: begin
                if (cfg_bus.cfg_update) begin
                    req_d = 1'b1;
                end
                if (snap_valid) begin
                    state_d = StPending;
                end else begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StPending: begin
                // A fresh write supersedes the pending one, even on a vsync edge.
                if (cfg_bus.cfg_update) begin
                    snap_take = 1'b1;
                    state_d   = StCheck;
                end else if (vs_rise) begin
                    state_d = StApply;
                end
            end
            StApply: begin
                if (cfg_bus.cfg_update) begin
                    req_d = 1'b1;
                end
                load    = 1'b1;
                err_d   = 1'b0;
                apply_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_vp or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            req_q     <= 1'b0;
            err_q     <= 1'b0;
            apply_q   <= 1'b0;
            snap_cr_q <= CrDflt;
            snap_sx_q <= '0;
            snap_ex_q <= HDisp;
            snap_sy_q <= '0;
            snap_ey_q <= VDisp;
            snap_ox_q <= HOutM1;
            snap_oy_q <= VOutM1;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            err_q   <= err_d;
            apply_q <= apply_d;
            if (snap_take) begin
                snap_cr_q <= cfg_bus.vp_cr[3:0];
                snap_sx_q <= cfg_bus.vp_start[XW-1:0];
                snap_sy_q <= cfg_bus.vp_start[16 +: YW];
                snap_ex_q <= cfg_bus.vp_end[XW-1:0];
                snap_ey_q <= cfg_bus.vp_end[16 +: YW];
                snap_ox_q <= cfg_bus.vp_scaler[OXW-1:0];
                snap_oy_q <= cfg_bus.vp_scaler[16 +: OYW];
            end
        end
    end

    always_ff @(posedge clk_vp or negedge rst_n) begin
        if (!rst_n) begin
            act_cr_q <= CrDflt;
            act_sx_q <= '0;
            act_ex_q <= HDisp;
            act_sy_q <= '0;
            act_ey_q <= VDisp;
            act_ix_q <= HDispM1;
            act_iy_q <= VDispM1;
            act_ox_q <= HOutM1;
            act_oy_q <= VOutM1;
        end else if (load) begin
            act_cr_q <= snap_cr_q;
            act_sx_q <= snap_sx_q;
            act_ex_q <= snap_ex_q;
            act_sy_q <= snap_sy_q;
            act_ey_q <= snap_ey_q;
            act_ix_q <= snap_ex_q - snap_sx_q - XW'(1);
            act_iy_q <= snap_ey_q - snap_sy_q - YW'(1);
            act_ox_q <= snap_ox_q;
            act_oy_q <= snap_oy_q;
        end
    end

    assign cuter_en_o       = act_cr_q[0];
    assign filter_mode_o    = act_cr_q[2:1];
    assign scaler_en_o      = act_cr_q[3];
    assign start_x_o        = act_sx_q;
    assign end_x_o          = act_ex_q;
    assign start_y_o        = act_sy_q;
    assign end_y_o          = act_ey_q;
    assign input_x_res_o    = act_ix_q;
    assign input_y_res_o    = act_iy_q;
    assign output_x_res_o   = act_ox_q;
    assign output_y_res_o   = act_oy_q;
    assign apply_pulse_o    = apply_q;
    assign frame_cnt_o      = frame_cnt_q;
    assign cfg_bus.cfg_busy = (state_q != StIdle) | req_q;
    assign cfg_bus.cfg_err  = err_q;
endmodule
